fp_unpack_pipe: RTL and testbench
=================================

Name: fp_unpack_pipe

Overview:
- Registered, handshaked floating-point field unpacker for a parametrised IEEE-754-style format.
- Splits the input into sign, exponent and mantissa and adds the hidden bit.
- Classifies the operand and optionally pre-normalises subnormals.
- Sits at the front of arithmetic datapaths (min/max, add, mul) as a one-stage pipeline register with valid/ready flow control.

Parameters:
- SIGN_W, 1, sign field width; only 1 is supported; the block raises an elaboration error otherwise.
- EXPO_W, 8, exponent field width.
- MANT_W, 23, stored mantissa field width, excluding the hidden bit. Requires MANT_W < 2^EXPO_W.
- NORM_SUB, 0, 1 selects subnormal pre-normalisation (left-shift and exponent adjust); 0 passes subnormals through unshifted.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept an operand this cycle
- ind  in  SIGN_W+EXPO_W+MANT_W  packed operand: sign at MSB, then exponent, then mantissa
- out_valid  out  1  output fields valid
- out_ready  in  1  downstream accepts the output
- out_sign  out  SIGN_W  sign bit
- out_expo  out  EXPO_W+2  signed effective biased exponent
- out_mant  out  MANT_W+1  significand including the hidden bit
- out_class  out  6  one-hot class: [5] snan, [4] qnan, [3] inf, [2] normal, [1] subnormal, [0] zero

Behaviour:
- Reset: while rst_n is low, out_valid=0, out_sign=0, out_expo=0, out_mant=0, out_class=0. Assertion is asynchronous; deassertion is sampled on clk.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, the output register loads the decoded fields and out_valid=1 on the next edge.
  - If there is no accept and out_ready=1, out_valid goes to 0 on the next edge.
  - While out_valid && !out_ready, all outputs hold stable.
- Latency: 1 cycle. Throughput: 1 operand/cycle when out_ready is held high. Simultaneous drain and accept in the same cycle replaces the output with no bubble.
- Decode: E = exponent field, M = mantissa field.
  - zero: E=0, M=0. expo=0, mant=0.
  - subnormal, NORM_SUB=0: E=0, M!=0. expo=1, mant={0,M}.
  - subnormal, NORM_SUB=1: E=0, M!=0. L = leading zeros of M within MANT_W bits. mant={0,M}<<(L+1), so the MSB is 1. expo = 1-(L+1) = -L, in two's complement.
  - normal: 0<E<all-ones. expo=E zero-extended, mant={1,M}.
  - inf: E all-ones, M=0. expo=E zero-extended, mant={1,0...}.
  - nan: E all-ones, M!=0. expo=E zero-extended, mant={1,M}. Class is qnan if M[MANT_W-1]=1, otherwise snan.
- Exactly one out_class bit is set whenever out_valid=1.
- The leading-zero count is a parametrised priority encoder, combinational within the stage.
- The sign passes through unchanged for all classes, including NaN and zero.
- Reset mid-operation drops any held output. There is no replay. The first accept after reset behaves as from idle.
- The out_expo width of EXPO_W+2 covers the full range -(MANT_W-1) .. 2^EXPO_W-1.

Test Plan:
- Defaults, NORM_SUB=0: ind=0x3F800000 with out_ready=1 -> next cycle out_valid=1, sign=0, expo=127, mant=0x800000, class=6'b000100.
- NORM_SUB=0: ind=0x00000001 -> expo=1, mant=0x000001, class=subnormal. With NORM_SUB=1 the same input gives mant=0x800000, expo=-22 (10-bit 0x3EA). With NORM_SUB=1, ind=0x00400000 gives mant=0x800000, expo=0.
- Special classes, in sequence:
  - 0x7F800000 -> inf, expo=255, mant=0x800000.
  - 0x7FC00000 -> qnan.
  - 0x7F800001 -> snan.
  - 0x80000000 -> zero, sign=1, expo=0, mant=0.
- Backpressure: stream 4 operands back-to-back. Hold out_ready=0 for 3 cycles after the first output -> in_ready=0, outputs stable, no operand lost or duplicated. Release out_ready -> the remaining 3 appear on consecutive cycles in order.
- Reset mid-operation: out_valid=1 and out_ready=0, then pulse rst_n low asynchronously between edges -> all outputs go to 0 immediately. After release, a new operand appears 1 cycle after accept.
- Alternate format EXPO_W=5, MANT_W=10 (fp16): ind=0x0001 with NORM_SUB=1 -> mant=0x400, expo=-9 (7-bit 0x77). ind=0x7E00 -> qnan.

Source files
------------

// File: rtl/fp_unpack_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fp_unpack_pipe: registered IEEE-754-style field unpacker/classifier      |
// | with valid/ready handshake and optional subnormal pre-normalisation.     |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module fp_unpack_pipe #(
  parameter int SIGN_W   = 1,
  parameter int EXPO_W   = 8,
  parameter int MANT_W   = 23,
  parameter int NORM_SUB = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] ind,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SIGN_W-1:0]             out_sign,
  output logic [EXPO_W+1:0]             out_expo,
  output logic [MANT_W:0]               out_mant,
  output logic [5:0]                    out_class
);

  localparam int W    = SIGN_W + EXPO_W + MANT_W;
  localparam int XW   = EXPO_W + 2;
  localparam int MW   = MANT_W + 1;
  localparam int LZ_W = $clog2(MANT_W + 1);

  generate
    if (SIGN_W != 1) begin : g_bad_sign
      $error("fp_unpack_pipe: only SIGN_W=1 is supported");
    end
    if (MANT_W >= (1 << EXPO_W)) begin : g_bad_mant
      $error("fp_unpack_pipe: MANT_W must be below 2**EXPO_W");
    end
  endgenerate

  logic [SIGN_W-1:0] f_sign;
  logic [EXPO_W-1:0] f_expo;
  logic [MANT_W-1:0] f_mant;
  logic              e_zero, e_ones, m_zero;

  assign f_sign = ind[W-1 -: SIGN_W];
  assign f_expo = ind[MANT_W +: EXPO_W];
  assign f_mant = ind[MANT_W-1:0];
  assign e_zero = (f_expo == '0);
  assign e_ones = &f_expo;
  assign m_zero = (f_mant == '0);

  // Leading zeros of the mantissa: the highest set bit wins.
  logic [LZ_W-1:0] lz;
  logic [LZ_W-1:0] shamt;
  always_comb begin
    lz = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (f_mant[i]) lz = LZ_W'(MANT_W - 1 - i);
    end
  end
  assign shamt = lz + LZ_W'(1);

  logic [XW-1:0] dec_expo;
  logic [MW-1:0] dec_mant;
  logic [5:0]    dec_class;

  always_comb begin
    dec_expo  = {2'b00, f_expo};
    dec_mant  = {1'b1, f_mant};
    dec_class = '0;
    if (e_zero) begin
      if (m_zero) begin
        dec_expo     = '0;
        dec_mant     = '0;
        dec_class[0] = 1'b1;
      end else begin
        dec_class[1] = 1'b1;
        if (NORM_SUB != 0) begin
          // Shift until the hidden-bit position is 1; exponent 1-(L+1) = -L.
          dec_mant = {1'b0, f_mant} << shamt;
          dec_expo = -XW'(lz);
        end else begin
          dec_mant = {1'b0, f_mant};
          dec_expo = XW'(1);
        end
      end
    end else if (e_ones) begin
      if (m_zero)                dec_class[3] = 1'b1;
      else if (f_mant[MANT_W-1]) dec_class[4] = 1'b1;
      else                       dec_class[5] = 1'b1;
    end else begin
      dec_class[2] = 1'b1;
    end
  end

  logic              valid_q, valid_d;
  logic [SIGN_W-1:0] sign_q,  sign_d;
  logic [XW-1:0]     expo_q,  expo_d;
  logic [MW-1:0]     mant_q,  mant_d;
  logic [5:0]        class_q, class_d;
  logic              accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    sign_d  = sign_q;
    expo_d  = expo_q;
    mant_d  = mant_q;
    class_d = class_q;
    if (accept) begin
      valid_d = 1'b1;
      sign_d  = f_sign;
      expo_d  = dec_expo;
      mant_d  = dec_mant;
      class_d = dec_class;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sign_q  <= '0;
      expo_q  <= '0;
      mant_q  <= '0;
      class_q <= '0;
    end else begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      expo_q  <= expo_d;
      mant_q  <= mant_d;
      class_q <= class_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sign  = sign_q;
  assign out_expo  = expo_q;
  assign out_mant  = mant_q;
  assign out_class = class_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_unpack_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fp_unpack_pipe: directed vector bench for fp_unpack_pipe (fp32 with  |
// | both subnormal modes, and fp16).  Revision: 1.0                          |
// +------------------------------------------------------------------------+
module tb_fp_unpack_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // fp32 stream shared by the NORM_SUB=0 and NORM_SUB=1 instances
  logic        a_in_valid = 1'b0;
  logic        a_out_ready = 1'b1;
  logic [31:0] a_ind = '0;

  logic        d0_in_ready, d0_out_valid, d0_sign;
  logic [9:0]  d0_expo;
  logic [23:0] d0_mant;
  logic [5:0]  d0_class;

  logic        d1_in_ready, d1_out_valid, d1_sign;
  logic [9:0]  d1_expo;
  logic [23:0] d1_mant;
  logic [5:0]  d1_class;

  logic        h_in_valid = 1'b0;
  logic        h_out_ready = 1'b1;
  logic [15:0] h_ind = '0;
  logic        h_in_ready, h_out_valid, h_sign;
  logic [6:0]  h_expo;
  logic [10:0] h_mant;
  logic [5:0]  h_class;

  fp_unpack_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .NORM_SUB(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(d0_in_ready),
    .ind(a_ind), .out_valid(d0_out_valid), .out_ready(a_out_ready),
    .out_sign(d0_sign), .out_expo(d0_expo), .out_mant(d0_mant), .out_class(d0_class));

  fp_unpack_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .NORM_SUB(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(d1_in_ready),
    .ind(a_ind), .out_valid(d1_out_valid), .out_ready(a_out_ready),
    .out_sign(d1_sign), .out_expo(d1_expo), .out_mant(d1_mant), .out_class(d1_class));

  fp_unpack_pipe #(.SIGN_W(1), .EXPO_W(5), .MANT_W(10), .NORM_SUB(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .ind(h_ind), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_sign(h_sign), .out_expo(h_expo), .out_mant(h_mant), .out_class(h_class));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] din;
    logic        sign;
    logic [9:0]  e0;
    logic [23:0] m0;
    logic [5:0]  c0;
    logic [9:0]  e1;
    logic [23:0] m1;
    logic [5:0]  c1;
  } vec32_t;

  typedef struct {
    logic [15:0] din;
    logic        sign;
    logic [6:0]  e;
    logic [10:0] m;
    logic [5:0]  c;
  } vec16_t;

  vec32_t t32[13];
  vec16_t t16[5];

  initial begin
    t32[0]  = '{32'h3F800000, 1'b0, 10'd127,  24'h800000, 6'b000100, 10'd127,  24'h800000, 6'b000100};
    t32[1]  = '{32'h00000001, 1'b0, 10'd1,    24'h000001, 6'b000010, 10'h3EA,  24'h800000, 6'b000010};
    t32[2]  = '{32'h00400000, 1'b0, 10'd1,    24'h400000, 6'b000010, 10'd0,    24'h800000, 6'b000010};
    t32[3]  = '{32'h7F800000, 1'b0, 10'd255,  24'h800000, 6'b001000, 10'd255,  24'h800000, 6'b001000};
    t32[4]  = '{32'h7FC00000, 1'b0, 10'd255,  24'hC00000, 6'b010000, 10'd255,  24'hC00000, 6'b010000};
    t32[5]  = '{32'h7F800001, 1'b0, 10'd255,  24'h800001, 6'b100000, 10'd255,  24'h800001, 6'b100000};
    t32[6]  = '{32'h80000000, 1'b1, 10'd0,    24'h000000, 6'b000001, 10'd0,    24'h000000, 6'b000001};
    t32[7]  = '{32'hC0490FDB, 1'b1, 10'd128,  24'hC90FDB, 6'b000100, 10'd128,  24'hC90FDB, 6'b000100};
    t32[8]  = '{32'h807FFFFF, 1'b1, 10'd1,    24'h7FFFFF, 6'b000010, 10'd0,    24'hFFFFFE, 6'b000010};
    t32[9]  = '{32'h00800000, 1'b0, 10'd1,    24'h800000, 6'b000100, 10'd1,    24'h800000, 6'b000100};
    t32[10] = '{32'h7F7FFFFF, 1'b0, 10'd254,  24'hFFFFFF, 6'b000100, 10'd254,  24'hFFFFFF, 6'b000100};
    t32[11] = '{32'hFFFFFFFF, 1'b1, 10'd255,  24'hFFFFFF, 6'b010000, 10'd255,  24'hFFFFFF, 6'b010000};
    t32[12] = '{32'h00000003, 1'b0, 10'd1,    24'h000003, 6'b000010, 10'h3EB,  24'hC00000, 6'b000010};

    t16[0] = '{16'h0001, 1'b0, 7'h77, 11'h400, 6'b000010};
    t16[1] = '{16'h7E00, 1'b0, 7'd31, 11'h600, 6'b010000};
    t16[2] = '{16'h3C00, 1'b0, 7'd15, 11'h400, 6'b000100};
    t16[3] = '{16'hFC00, 1'b1, 7'd31, 11'h400, 6'b001000};
    t16[4] = '{16'h7D00, 1'b0, 7'd31, 11'h500, 6'b100000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(d0_out_valid), 32'd0);
    chk("rst_expo",  32'(d0_expo),      32'd0);
    chk("rst_mant",  32'(d0_mant),      32'd0);
    chk("rst_class", 32'(d0_class),     32'd0);
    chk("rst_in_ready", 32'(d0_in_ready), 32'd1);
    rst_n = 1'b1;

    // fp32 vectors, back-to-back on both instances
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      a_in_valid = 1'b1;
      a_ind      = t32[i].din;
      @(negedge clk);
      chk($sformatf("v%0d_valid0", i), 32'(d0_out_valid), 32'd1);
      chk($sformatf("v%0d_sign0",  i), 32'(d0_sign),  32'(t32[i].sign));
      chk($sformatf("v%0d_expo0",  i), 32'(d0_expo),  32'(t32[i].e0));
      chk($sformatf("v%0d_mant0",  i), 32'(d0_mant),  32'(t32[i].m0));
      chk($sformatf("v%0d_class0", i), 32'(d0_class), 32'(t32[i].c0));
      chk($sformatf("v%0d_sign1",  i), 32'(d1_sign),  32'(t32[i].sign));
      chk($sformatf("v%0d_expo1",  i), 32'(d1_expo),  32'(t32[i].e1));
      chk($sformatf("v%0d_mant1",  i), 32'(d1_mant),  32'(t32[i].m1));
      chk($sformatf("v%0d_class1", i), 32'(d1_class), 32'(t32[i].c1));
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 32'(d0_out_valid), 32'd0);

    // fp16 vectors
    for (int i = 0; i < 5; i++) begin
      h_in_valid = 1'b1;
      h_ind      = t16[i].din;
      @(negedge clk);
      chk($sformatf("h%0d_valid", i), 32'(h_out_valid), 32'd1);
      chk($sformatf("h%0d_sign",  i), 32'(h_sign),  32'(t16[i].sign));
      chk($sformatf("h%0d_expo",  i), 32'(h_expo),  32'(t16[i].e));
      chk($sformatf("h%0d_mant",  i), 32'(h_mant),  32'(t16[i].m));
      chk($sformatf("h%0d_class", i), 32'(h_class), 32'(t16[i].c));
    end
    h_in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: A then stall three cycles, then B, C, D consecutively
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_ind       = 32'h3F800000;
    @(negedge clk);
    chk("bp_a_expo", 32'(d0_expo), 32'd127);
    a_out_ready = 1'b0;
    a_ind       = 32'h40000000;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_in_ready", 32'(d0_in_ready),  32'd0);
      chk("bp_stall_valid",    32'(d0_out_valid), 32'd1);
      chk("bp_stall_expo",     32'(d0_expo),      32'd127);
      chk("bp_stall_mant",     32'(d0_mant),      32'h800000);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", 32'(d0_out_valid), 32'd1);
    chk("bp_b_expo",  32'(d0_expo), 32'd128);
    chk("bp_b_mant",  32'(d0_mant), 32'h800000);
    a_ind = 32'h40400000;
    @(negedge clk);
    chk("bp_c_valid", 32'(d0_out_valid), 32'd1);
    chk("bp_c_expo",  32'(d0_expo), 32'd128);
    chk("bp_c_mant",  32'(d0_mant), 32'hC00000);
    a_ind = 32'h40800000;
    @(negedge clk);
    chk("bp_d_valid", 32'(d0_out_valid), 32'd1);
    chk("bp_d_expo",  32'(d0_expo), 32'd129);
    chk("bp_d_mant",  32'(d0_mant), 32'h800000);
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("bp_end_valid", 32'(d0_out_valid), 32'd0);

    // Asynchronous reset while an output is held
    a_in_valid  = 1'b1;
    a_ind       = 32'hBF800000;
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("ar_held_valid", 32'(d0_out_valid), 32'd1);
    chk("ar_held_sign",  32'(d0_sign),      32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(d0_out_valid), 32'd0);
    chk("ar_sign",  32'(d0_sign),  32'd0);
    chk("ar_expo",  32'(d0_expo),  32'd0);
    chk("ar_mant",  32'(d0_mant),  32'd0);
    chk("ar_class", 32'(d0_class), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_idle_valid", 32'(d0_out_valid), 32'd0);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_ind       = 32'h40000000;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("ar_new_valid", 32'(d0_out_valid), 32'd1);
    chk("ar_new_expo",  32'(d0_expo),  32'd128);
    chk("ar_new_class", 32'(d0_class), 32'b000100);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
